// File: rtl/arb_pkg.sv
// Shared types and helpers for the priority arbiter: FSM state encoding and
// a constant clog2 used to size index ports.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search: scans req downward starting at ptr, wrapping
// from index 0 back to N-1, and reports the first set bit.
module prio_pick
  import arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  int pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) - k;
      if (pos < 0) pos = pos + N;
      if (!any && req[pos[W-1:0]]) begin
        any = 1'b1;
        idx = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Two-state request arbiter with fixed or round-robin priority, hold timeout
// and disable; every output is a register.
module priority_arbiter
  import arb_pkg::*;
#(
  parameter int N   = 8,
  parameter int RR  = 0,
  parameter int TMO = 15,
  localparam int W  = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dis,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_oh,
  output logic         tmo
);

  localparam logic [W-1:0] LAST    = W'(N - 1);
  localparam logic [7:0]   TMO_LIM = 8'(TMO);
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [7:0]     hold_cnt;
  logic [7:0]     hold_next;
  logic [W-1:0]   ptr;
  logic [W-1:0]   pick_ptr;
  logic [W-1:0]   pick_idx;
  logic           pick_any;
  logic [W-1:0]   ptr_after;
  logic           timeout;

  // Fixed priority is just round-robin with the pointer pinned at the top index.
  assign pick_ptr  = (RR != 0) ? ptr : LAST;
  assign hold_next = hold_cnt + 8'd1;
  assign timeout   = (TMO != 0) && (hold_next == TMO_LIM);
  assign ptr_after = (gnt_idx == '0) ? LAST : gnt_idx - 1'b1;

  prio_pick #(.N(N), .W(W)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      gnt_oh    <= '0;
      tmo       <= 1'b0;
      hold_cnt  <= 8'd0;
      ptr       <= LAST;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (!dis && pick_any) begin
            state     <= GRANT;
            gnt_valid <= 1'b1;
            gnt_idx   <= pick_idx;
            gnt_oh    <= ONE << pick_idx;
            hold_cnt  <= 8'd0;
          end
        end
        GRANT: begin
          // Ack beats both disable and timeout; only ack and timeout rotate ptr.
          if (ack) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            gnt_oh    <= '0;
            if (RR != 0) ptr <= ptr_after;
          end else if (dis) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            gnt_oh    <= '0;
          end else begin
            hold_cnt <= hold_next;
            if (timeout) begin
              state     <= IDLE;
              gnt_valid <= 1'b0;
              gnt_idx   <= '0;
              gnt_oh    <= '0;
              tmo       <= 1'b1;
              if (RR != 0) ptr <= ptr_after;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 8: number of request inputs, legal range 2..32.
REQ-002 Parameter RR, default 0: 0 selects fixed priority, 1 selects round-robin.
REQ-003 Parameter TMO, default 15: maximum GRANT cycles without acknowledge; 0 disables the timeout; legal range 0..255.
REQ-004 Derived W = clog2(N).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 dis  input  1  active-high disable; blocks new grants and releases any held grant.
REQ-008 req  input  N  request lines; bit i asserted means requester i wants service.
REQ-009 ack  input  1  consumer acknowledge of the current grant.
REQ-010 gnt_valid  output  1  a grant is held.
REQ-011 gnt_idx  output  W  binary index of the granted requester; zero when gnt_valid=0.
REQ-012 gnt_oh  output  N  one-hot form of gnt_idx; all zero when gnt_valid=0.
REQ-013 tmo  output  1  one-cycle pulse when a grant is released by timeout.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and GRANT; all outputs SHALL be registered.
REQ-015 In IDLE with dis=0 and req!=0, the block SHALL capture a winner and enter GRANT, with gnt_valid=1 on the next cycle (latency 1).
REQ-016 In IDLE with dis=1 or req=0, the block SHALL remain in IDLE and keep all outputs zero.
REQ-017 With RR=0, the highest set req index SHALL win.
REQ-018 With RR=1, priority SHALL descend from index ptr, wrapping from 0 to N-1; ptr SHALL be a W-bit register.
REQ-019 After any release by ack or timeout, ptr SHALL become (idx-1) mod N, so the previous winner has lowest priority; with RR=0, ptr SHALL be unused.
REQ-020 In GRANT, gnt_idx and gnt_oh SHALL hold stable until release, regardless of changes on req, including deassertion of the granted request.
REQ-021 In GRANT, ack=1 SHALL return the FSM to IDLE with gnt_valid=0 on the next cycle; a new grant SHALL need at least one IDLE cycle (one-cycle bubble).
REQ-022 ack received in IDLE SHALL be ignored.
REQ-023 In GRANT, dis=1 without ack SHALL release to IDLE on the next cycle, leave ptr unchanged, and not pulse tmo.
REQ-024 When ack and dis are both high in GRANT, ack SHALL take precedence: release and update ptr.
REQ-025 An 8-bit hold counter SHALL clear on GRANT entry and increment each GRANT cycle without ack.
REQ-026 When TMO>0 and the hold counter reaches TMO, the block SHALL release to IDLE, pulse tmo for one cycle, and update ptr as for ack.
REQ-027 When ack arrives on the same cycle the counter reaches TMO, ack SHALL win and tmo SHALL not pulse.

Reset
REQ-028 rst_n=0 on a rising edge SHALL force IDLE, gnt_valid=0, gnt_idx=0, gnt_oh=0, tmo=0, hold counter=0, and ptr=N-1, including mid-grant.
REQ-029 After reset, round-robin order SHALL equal fixed-priority order until the first release.

Structure
REQ-030 The shared package arb_pkg SHALL hold the state enum (IDLE, GRANT) and the clog2 constant function.
REQ-031 The winner search SHALL be a combinational sub-module prio_pick (inputs req and ptr; outputs idx and any), instantiated once.

Verification
REQ-032 N=8, RR=0: req=8'b0010_0110 in IDLE -> next cycle gnt_valid=1, gnt_idx=5, gnt_oh=8'b0010_0000; ack -> gnt_valid=0 the cycle after.
REQ-033 N=8, RR=1: hold req=8'hFF and ack every grant -> successive gnt_idx 7,6,5,...,0,7, with one idle cycle between grants.
REQ-034 TMO=4: grant idx 3 with no ack -> release after 4 GRANT cycles, tmo=1 for one cycle; with RR=1, the next grant from req=8'h0C is 2.
REQ-035 dis=1 with req=8'h01 -> no grant; in GRANT, dis=1 -> gnt_valid=0 next cycle, tmo=0, ptr unchanged.
REQ-036 rst_n=0 during GRANT idx 6 -> all outputs zero next cycle and ptr=7; req=8'h41 afterwards -> grant idx 6.
REQ-037 In GRANT idx 2, req drops to 0 -> grant held until ack; ack and dis on the same cycle -> ptr updated to 1.
